// File: rtl/xg_hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage F/D/E/M/W pipeline.
// Stall, flush and forward selects are combinational (zero latency); a memory wait freezes F..M until ready or timeout.
module xg_hazard_unit #(
  parameter int RFIDX_WIDTH = 5,
  parameter int FWD_EN      = 1,
  parameter int RF_BYPASS   = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RFIDX_WIDTH-1:0] rs1D,
  input  logic [RFIDX_WIDTH-1:0] rs2D,
  input  logic                   use1D,
  input  logic                   use2D,
  input  logic                   ctrlD,
  input  logic                   pcsrcD,
  input  logic [RFIDX_WIDTH-1:0] rs1E,
  input  logic [RFIDX_WIDTH-1:0] rs2E,
  input  logic [RFIDX_WIDTH-1:0] rdE,
  input  logic                   regwriteE,
  input  logic                   memtoregE,
  input  logic [RFIDX_WIDTH-1:0] rdM,
  input  logic                   regwriteM,
  input  logic                   memtoregM,
  input  logic                   mem_reqM,
  input  logic                   mem_readyM,
  input  logic [RFIDX_WIDTH-1:0] rdW,
  input  logic                   regwriteW,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   stallE,
  output logic                   stallM,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   flushW,
  output logic [1:0]             forwardaE,
  output logic [1:0]             forwardbE,
  output logic                   forwardaD,
  output logic                   forwardbD,
  output logic                   mem_err,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic {IDLE, WAIT} mstate_t;

  mstate_t           state, next_state;
  logic [WCNT_W-1:0] wcnt, wcnt_next;
  logic              tmo, memstall, hazard;
  logic              dep_e, dep_m, dep_w;
  logic              fwd_a_m, fwd_a_w, fwd_b_m, fwd_b_w;

  // x0 is hardwired zero, so it never creates a dependency
  function automatic logic hit(input logic [RFIDX_WIDTH-1:0] a, input logic [RFIDX_WIDTH-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign dep_e = regwriteE & ((use1D & hit(rs1D, rdE)) | (use2D & hit(rs2D, rdE)));
  assign dep_m = regwriteM & ((use1D & hit(rs1D, rdM)) | (use2D & hit(rs2D, rdM)));
  assign dep_w = regwriteW & ((use1D & hit(rs1D, rdW)) | (use2D & hit(rs2D, rdW)));

  assign fwd_a_m = regwriteM & hit(rdM, rs1E);
  assign fwd_a_w = regwriteW & hit(rdW, rs1E);
  assign fwd_b_m = regwriteM & hit(rdM, rs2E);
  assign fwd_b_w = regwriteW & hit(rdW, rs2E);

  assign tmo      = (state == WAIT) && (wcnt == WCNT_W'(MEM_TIMEOUT - 1));
  assign memstall = mem_reqM & ~mem_readyM & ~tmo;

  always_comb begin
    if (FWD_EN != 0)
      hazard = (memtoregE & dep_e) | (ctrlD & (dep_e | (memtoregM & dep_m)));
    else
      hazard = dep_e | dep_m | (dep_w & (RF_BYPASS == 0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      wcnt  <= wcnt_next;
      if (tmo)
        mem_err <= 1'b1;
      if (stallF && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = IDLE;
    wcnt_next  = '0;
    case (state)
      IDLE: begin
        if (memstall) begin
          next_state = WAIT;
          wcnt_next  = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (memstall) begin
          next_state = WAIT;
          wcnt_next  = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE;
        wcnt_next  = '0;
      end
    endcase
  end

  // A redirect is dropped while stalled; the branch re-presents it once the stall clears
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    forwardaD = 1'b0;
    forwardbD = 1'b0;
    if (!reset) begin
      if (memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (hazard) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else if (pcsrcD) begin
        flushD = 1'b1;
      end
      if (FWD_EN != 0) begin
        forwardaE = fwd_a_m ? 2'b10 : (fwd_a_w ? 2'b01 : 2'b00);
        forwardbE = fwd_b_m ? 2'b10 : (fwd_b_w ? 2'b01 : 2'b00);
        forwardaD = ctrlD & regwriteM & ~memtoregM & hit(rdM, rs1D);
        forwardbD = ctrlD & regwriteM & ~memtoregM & hit(rdM, rs2D);
      end
    end
  end

endmodule

// File: tb/tb_xg_hazard_unit.sv
// Randomized and directed checks of xg_hazard_unit in forwarding and stall-only configurations.
module tb_xg_hazard_unit;

  typedef struct packed {
    logic [4:0] rs1D, rs2D;
    logic       use1D, use2D, ctrlD, pcsrcD;
    logic [4:0] rs1E, rs2E, rdE;
    logic       regwriteE, memtoregE;
    logic [4:0] rdM;
    logic       regwriteM, memtoregM, mem_reqM, mem_readyM;
    logic [4:0] rdW;
    logic       regwriteW;
  } in_t;

  logic clk = 1'b0;
  logic reset;
  in_t  in;

  int tests = 0;
  int fails = 0;

  logic       a_sF, a_sD, a_sE, a_sM, a_fD, a_fE, a_fW, a_faD, a_fbD, a_err;
  logic [1:0] a_faE, a_fbE;
  logic [15:0] a_cnt;
  logic       b_sF, b_sD, b_sE, b_sM, b_fD, b_fE, b_fW, b_faD, b_fbD, b_err;
  logic [1:0] b_faE, b_fbE;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  xg_hazard_unit #(.RFIDX_WIDTH(5), .FWD_EN(1), .RF_BYPASS(1), .MEM_TIMEOUT(16), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .rs1D(in.rs1D), .rs2D(in.rs2D), .use1D(in.use1D), .use2D(in.use2D),
    .ctrlD(in.ctrlD), .pcsrcD(in.pcsrcD), .rs1E(in.rs1E), .rs2E(in.rs2E), .rdE(in.rdE),
    .regwriteE(in.regwriteE), .memtoregE(in.memtoregE), .rdM(in.rdM), .regwriteM(in.regwriteM),
    .memtoregM(in.memtoregM), .mem_reqM(in.mem_reqM), .mem_readyM(in.mem_readyM), .rdW(in.rdW),
    .regwriteW(in.regwriteW), .stallF(a_sF), .stallD(a_sD), .stallE(a_sE), .stallM(a_sM),
    .flushD(a_fD), .flushE(a_fE), .flushW(a_fW), .forwardaE(a_faE), .forwardbE(a_fbE),
    .forwardaD(a_faD), .forwardbD(a_fbD), .mem_err(a_err), .stall_cnt(a_cnt));

  xg_hazard_unit #(.RFIDX_WIDTH(5), .FWD_EN(0), .RF_BYPASS(0), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .rs1D(in.rs1D), .rs2D(in.rs2D), .use1D(in.use1D), .use2D(in.use2D),
    .ctrlD(in.ctrlD), .pcsrcD(in.pcsrcD), .rs1E(in.rs1E), .rs2E(in.rs2E), .rdE(in.rdE),
    .regwriteE(in.regwriteE), .memtoregE(in.memtoregE), .rdM(in.rdM), .regwriteM(in.regwriteM),
    .memtoregM(in.memtoregM), .mem_reqM(in.mem_reqM), .mem_readyM(in.mem_readyM), .rdW(in.rdW),
    .regwriteW(in.regwriteW), .stallF(b_sF), .stallD(b_sD), .stallE(b_sE), .stallM(b_sM),
    .flushD(b_fD), .flushE(b_fE), .flushW(b_fW), .forwardaE(b_faE), .forwardbE(b_fbE),
    .forwardaD(b_faD), .forwardbD(b_fbD), .mem_err(b_err), .stall_cnt(b_cnt));

  wire [13:0] a_out = {a_sF, a_sD, a_sE, a_sM, a_fD, a_fE, a_fW, a_faE, a_fbE, a_faD, a_fbD, a_err};
  wire [13:0] b_out = {b_sF, b_sD, b_sE, b_sM, b_fD, b_fE, b_fW, b_faE, b_fbE, b_faD, b_fbD, b_err};

  // Reference model state, one slot per configuration
  int cfg_fwd[2] = '{1, 0};
  int cfg_byp[2] = '{1, 0};
  int cfg_to[2]  = '{16, 4};
  int cfg_max[2] = '{65535, 3};
  int m_wait[2];     // consecutive cycles already spent waiting on memory
  int m_err[2];
  int m_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit nz_eq(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  // Does the D instruction read a register that this producer writes?
  function automatic bit needs(input logic [4:0] rd, input logic we);
    return we && ((in.use1D && nz_eq(in.rs1D, rd)) || (in.use2D && nz_eq(in.rs2D, rd)));
  endfunction

  function automatic int esel(input int fwd, input logic [4:0] rs);
    if (fwd == 0) return 0;
    if (in.regwriteM && nz_eq(in.rdM, rs)) return 2;
    if (in.regwriteW && nz_eq(in.rdW, rs)) return 1;
    return 0;
  endfunction

  task automatic model_step(input int k, output logic [13:0] exp);
    bit tmo, mstall, haz, sF, sD, sE, sM, fD, fE, fW, faD, fbD;
    int faE, fbE;
    {sF, sD, sE, sM, fD, fE, fW, faD, fbD} = '0;
    faE = 0;
    fbE = 0;
    tmo    = (m_wait[k] == cfg_to[k] - 1);
    mstall = in.mem_reqM && !in.mem_readyM && !tmo;
    if (cfg_fwd[k] != 0)
      haz = (in.memtoregE && needs(in.rdE, in.regwriteE)) ||
            (in.ctrlD && (needs(in.rdE, in.regwriteE) || (in.memtoregM && needs(in.rdM, in.regwriteM))));
    else
      haz = needs(in.rdE, in.regwriteE) || needs(in.rdM, in.regwriteM) ||
            (cfg_byp[k] == 0 && needs(in.rdW, in.regwriteW));
    if (!reset) begin
      if (mstall) {sF, sD, sE, sM, fW} = 5'b11111;
      else if (haz) {sF, sD, fE} = 3'b111;
      else if (in.pcsrcD) fD = 1;
      faE = esel(cfg_fwd[k], in.rs1E);
      fbE = esel(cfg_fwd[k], in.rs2E);
      if (cfg_fwd[k] != 0 && in.ctrlD && in.regwriteM && !in.memtoregM) begin
        faD = nz_eq(in.rdM, in.rs1D);
        fbD = nz_eq(in.rdM, in.rs2D);
      end
    end
    exp = {sF, sD, sE, sM, fD, fE, fW, faE[1:0], fbE[1:0], faD, fbD, m_err[k][0]};
    if (reset) begin
      m_wait[k] = 0;
      m_err[k]  = 0;
      m_cnt[k]  = 0;
    end else begin
      m_wait[k] = mstall ? m_wait[k] + 1 : 0;
      if (tmo) m_err[k] = 1;
      if (sF && m_cnt[k] < cfg_max[k]) m_cnt[k]++;
    end
  endtask

  // Inputs are set at the falling edge; compare once they have settled.
  task automatic settle();
    logic [13:0] ea, eb;
    int ca, cb;
    #1;
    ca = m_cnt[0];
    cb = m_cnt[1];
    check("cnt_a", 32'(a_cnt), 32'(ca));
    check("cnt_b", 32'(b_cnt), 32'(cb));
    model_step(0, ea);
    model_step(1, eb);
    check("out_a", 32'(a_out), 32'(ea));
    check("out_b", 32'(b_out), 32'(eb));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    in = '0;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    settle();
  endtask

  initial begin
    int n;
    in = '0;
    reset = 1'b1;
    m_wait = '{0, 0};
    m_err  = '{0, 0};
    m_cnt  = '{0, 0};
    repeat (2) @(negedge clk);
    settle();
    check("rst_stallF", 32'(a_sF), 0);
    check("rst_cnt", 32'(a_cnt), 0);

    // Load-use: lw x5 in E, consumer of x5 in D
    next_cycle();
    in.rdE = 5; in.regwriteE = 1; in.memtoregE = 1; in.rs1D = 5; in.use1D = 1; in.rs2D = 7;
    settle();
    check("ld_stall", 32'({a_sF, a_sD, a_fE}), 32'h7);
    next_cycle();
    in.rs1E = 5; in.rs2E = 7; in.rdW = 5; in.regwriteW = 1;
    settle();
    check("ld_fwdW", 32'(a_faE), 1);
    check("ld_cnt", 32'(a_cnt), 1);

    // E forwarding priority
    next_cycle();
    in.rdM = 3; in.regwriteM = 1; in.rdW = 3; in.regwriteW = 1; in.rs1E = 3;
    settle();
    check("fwdE_M", 32'(a_faE), 2);
    next_cycle();
    in.rdM = 3; in.rdW = 3; in.regwriteW = 1; in.rs1E = 3;
    settle();
    check("fwdE_W", 32'(a_faE), 1);
    next_cycle();
    in.rdM = 0; in.regwriteM = 1; in.rdW = 0; in.regwriteW = 1; in.rs1E = 0;
    settle();
    check("fwdE_x0", 32'(a_faE), 0);

    // Branch operand hazard with a coincident redirect
    next_cycle();
    in.ctrlD = 1; in.pcsrcD = 1; in.rs1D = 4; in.use1D = 1; in.rdE = 4; in.regwriteE = 1;
    settle();
    check("br_stall", 32'(a_sF), 1);
    check("br_noflush", 32'(a_fD), 0);
    next_cycle();
    in.ctrlD = 1; in.pcsrcD = 1; in.rs1D = 4; in.use1D = 1; in.rdM = 4; in.regwriteM = 1;
    settle();
    check("br_fwdD", 32'(a_faD), 1);
    check("br_flush", 32'({a_sF, a_fD}), 1);

    // Memory wait of three cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      in.mem_reqM = 1; in.mem_readyM = (i == 3);
      settle();
      check("mw_stall", 32'({a_sF, a_sD, a_sE, a_sM, a_fW}), (i < 3) ? 32'h1f : 32'h0);
    end
    next_cycle();
    settle();
    check("mw_err", 32'(a_err), 0);
    check("mw_cnt", 32'(a_cnt), 3);

    // Memory timeout
    n = 0;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      in.mem_reqM = 1;
      settle();
      n += a_sM;
      if (i == 15) check("to_release", 32'(a_sM), 0);
    end
    check("to_stalls", 32'(n), 15);
    next_cycle();
    settle();
    check("to_err", 32'(a_err), 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      in.mem_reqM = 1;
      settle();
    end
    check("to_err_sticky", 32'(a_err), 1);
    do_reset();
    check("rst_mid_out", 32'(a_out[13:1]), 0);
    next_cycle();
    settle();
    check("rst_mid_cnt", 32'(a_cnt), 0);
    check("rst_mid_err", 32'(a_err), 0);

    // Stall-only configuration: producer of x9 walks E, M, W
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      in.rs1D = 9; in.use1D = 1;
      if (i == 0) begin in.rdE = 9; in.regwriteE = 1; end
      if (i == 1) begin in.rdM = 9; in.regwriteM = 1; in.rs1E = 9; end
      if (i == 2) begin in.rdW = 9; in.regwriteW = 1; in.rs1E = 9; end
      settle();
      check("walk_stall", 32'(b_sF), (i < 3) ? 32'h1 : 32'h0);
      check("walk_fwd", 32'({b_faE, b_fbE}), 0);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      in.rs1D = 9; in.use1D = 1; in.rdE = 9; in.regwriteE = 1;
      settle();
    end
    next_cycle();
    settle();
    check("sat_cnt", 32'(b_cnt), 3);

    // Randomized traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      reset = ($urandom_range(0, 199) == 0);
      in.rs1D = 5'($urandom_range(0, 3));  in.rs2D = 5'($urandom_range(0, 3));
      in.rs1E = 5'($urandom_range(0, 3));  in.rs2E = 5'($urandom_range(0, 3));
      in.rdE  = 5'($urandom_range(0, 3));  in.rdM  = 5'($urandom_range(0, 3));
      in.rdW  = 5'($urandom_range(0, 3));
      {in.use1D, in.use2D, in.ctrlD, in.pcsrcD} = 4'($urandom);
      {in.regwriteE, in.memtoregE, in.regwriteM, in.memtoregM, in.regwriteW} = 5'($urandom);
      in.mem_reqM   = ($urandom_range(0, 2) == 0);
      in.mem_readyM = (i % 512 > 480) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (i % 512 > 480) in.mem_reqM = 1;
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xg_hazard_unit.md
Name: xg_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the 5-stage xgriscv pipeline (F/D/E/M/W).
- Produces the stall, flush and forwarding selects that the datapath pipeline registers and operand muxes consume.
- Handles load-use hazards, D-stage branch/jalr operand hazards, taken-branch flushes and variable-latency data-memory waits with a timeout.
- Forwarding can be disabled by parameter, giving a stall-only mode. A saturating stall-cycle performance counter is included.

Parameters:
- RFIDX_WIDTH, 5, register index width.
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall until the producer reaches W.
- RF_BYPASS, 1, 1 = regfile write-through (W write visible to D read in the same cycle); 0 = a W-stage match is also a hazard.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_readyM before forced release (≥2).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rs1D, rs2D  in  RFIDX_WIDTH  D-stage source indices
- use1D, use2D  in  1  D instruction actually reads rs1/rs2
- ctrlD  in  1  D instruction consumes operands in D (branch, jalr)
- pcsrcD  in  1  D-stage redirect taken
- rs1E, rs2E, rdE  in  RFIDX_WIDTH  E-stage indices
- regwriteE, memtoregE  in  1  E-stage control
- rdM  in  RFIDX_WIDTH  M-stage destination
- regwriteM, memtoregM  in  1  M-stage control
- mem_reqM  in  1  M stage is a load or store
- mem_readyM  in  1  data memory completes this cycle
- rdW  in  RFIDX_WIDTH  W-stage destination
- regwriteW  in  1  W-stage control
- stallF, stallD, stallE, stallM  out  1  hold the pipeline register / PC
- flushD, flushE, flushW  out  1  insert a bubble
- forwardaE, forwardbE  out  2  00 regfile, 01 wdataW, 10 aluoutM (mux3 encoding)
- forwardaD, forwardbD  out  1  1 = comparator/jalr operand from aluoutM
- mem_err  out  1  sticky: a memory timeout occurred
- stall_cnt  out  CNT_W  saturating count of cycles with stallF=1

Behaviour:
- Register x0 never matches: any index equal to 0 yields no forward and no stall.
- matchXY means: index match AND the producer's regwrite AND the use bit.
- Reset (synchronous):
  - FSM goes to IDLE; wait counter, stall_cnt and mem_err go to 0.
  - While reset=1, all stall/flush outputs are 0 and all forward selects are 0.
- Memory FSM:
  - States: IDLE, WAIT. A wait counter wcnt runs while in WAIT.
  - memstall = mem_reqM & ~mem_readyM & ~tmo, where tmo = (state==WAIT) & (wcnt==MEM_TIMEOUT-1).
  - IDLE→WAIT on memstall; wcnt is loaded with 1.
  - WAIT stays in WAIT while memstall; wcnt increments.
  - WAIT→IDLE on mem_readyM (stall released in that same cycle) or on tmo. On tmo, mem_err is set, the stall is released and the instruction advances.
  - mem_readyM=1 in the request cycle gives zero stall and no WAIT entry.
- Hazard terms, with FWD_EN=1:
  - lduse = memtoregE & match(rdE vs rs1D/rs2D).
  - brhaz = ctrlD & (regwriteE & match(rdE) | memtoregM & match(rdM)).
- Hazard terms, with FWD_EN=0:
  - datahaz = any match of rs1D/rs2D against rdE or rdM. If RF_BYPASS=0, a match against rdW also counts.
- Priority (one cycle):
  1. memstall: stallF=stallD=stallE=stallM=1, flushW=1, no other flush.
  2. Otherwise lduse, brhaz or datahaz: stallF=stallD=1, flushE=1.
  3. Otherwise pcsrcD: flushD=1.
  - A redirect coincident with a stall is suppressed; it is re-evaluated after the stall clears.
- E forwarding (FWD_EN=1; otherwise forced to 00):
  - 10 if regwriteM & rdM==rs1E (resp. rs2E), non-zero.
  - Else 01 if regwriteW & rdW match, non-zero.
  - Else 00.
  - The M source has priority over W.
- D forwarding (FWD_EN=1): forwardaD = ctrlD & regwriteM & ~memtoregM & rdM==rs1D, non-zero; forwardbD likewise on rs2D.
- stall_cnt increments in every cycle with stallF=1 and saturates at all-ones.
- All outputs other than FSM/counter state are combinational from inputs and state; there is no added latency.

Test Plan:
- lw x5 in E, add x6,x5,x7 in D (use1D=1) → one cycle of stallF=stallD=flushE=1; next cycle forwardaE=01, stall_cnt=1.
- add x3 in M, sub reading x3 in E, same x3 also in W → forwardaE=10 (M priority); with regwriteM=0 → 01; with rs1E=0 → 00.
- beq in D (ctrlD=1) with rdE=rs1D=4, regwriteE=1 → 1-cycle stall; then rdM=4 non-load → forwardaD=1. With pcsrcD=1 in the same cycle as the stall → flushD=0 until the stall clears, then flushD=1.
- mem_reqM=1, mem_readyM=0 for 3 cycles then 1 → stallF..M=flushW=1 for exactly 3 cycles, released on the ready cycle, FSM back to IDLE, mem_err=0.
- mem_readyM held 0 with MEM_TIMEOUT=16 → 15 stall cycles, then release; mem_err=1 sticky until reset. Assert reset mid-WAIT → all outputs 0, FSM IDLE, stall_cnt=0.
- FWD_EN=0, RF_BYPASS=0: producer of x9 walks E→M→W while the consumer sits in D → 3 stall cycles, forward selects always 00. With CNT_W=2, after 5 stalls stall_cnt=3.
